router_1xn: RTL and testbench
=============================

# router_1xn

Parametrised 1-to-N packet router: one byte-stream input, NUM_PORTS independent output FIFOs, header-based address decode, input flow control, parity checking, invalid-address drop, and per-port read-timeout flush. Successor of the fixed 1x3 router top; it sits between the packet source and N downstream readers and is delivered as one top plus one FIFO sub-module.

## Interface
- DATA_W, 8: byte width; header address field is din[ADDR_W-1:0].
- NUM_PORTS, 3: output channels, 2..8; ADDR_W = max(1, clog2(NUM_PORTS)).
- FIFO_DEPTH, 16: entries per port FIFO, power of two, ≥4.
- TIMEOUT, 30: consecutive unread cycles before a port is flushed, ≥1.
- clk  in  1  single clock, rising edge.
- rstn  in  1  asynchronous reset, active-high (asserted = 1).
- pkt_valid  in  1  high for header and payload bytes; the first low cycle after a packet carries the parity byte.
- din  in  DATA_W  input byte.
- re  in  NUM_PORTS  per-port read enable.
- data_out  out  NUM_PORTS*DATA_W  port i head byte at [i*DATA_W +: DATA_W].
- valid_out  out  NUM_PORTS  port i FIFO non-empty.
- busy  out  1  source must hold din/pkt_valid this cycle.
- error  out  1  parity mismatch of the last completed packet.
- drop  out  1  one-cycle pulse: packet discarded.

## Operation
- A byte is consumed on any clock edge where busy=0 and the FSM accepts it; otherwise the source holds it.
- FSM states IDLE, LOAD, DROP; dest register holds the decoded port.
- IDLE, pkt_valid=0: nothing. pkt_valid=1: addr = din[ADDR_W-1:0].
  - addr ≥ NUM_PORTS: consume header, pulse drop, → DROP.
  - FIFO[addr] not empty: busy=1, stay IDLE (header not consumed).
  - FIFO[addr] empty: write header, dest ← addr, parity accumulator ← din, error ← 0, → LOAD.
- LOAD, FIFO[dest] full: busy=1, no write. Not full and pkt_valid=1: write din, accumulator ^= din. Not full and pkt_valid=0: din is parity; write it, evaluate error, → IDLE.
- DROP: consume and discard everything; on first pkt_valid=0 cycle (parity byte) → IDLE.
- busy = (IDLE & pkt_valid & addr valid & !empty[addr]) | (LOAD & full[dest]); combinational, 0 in DROP.
- Output side: first-word-fall-through; valid_out[i] = !empty[i]; data_out slice = head entry, 0 when empty; re[i] & valid_out[i] pops at the edge; re on empty ignored.
- Timeout: per-port counter increments while valid_out[i]=1 & re[i]=0, clears otherwise; on reaching TIMEOUT, port FIFO flushed at that edge, counter cleared.
- Flush of dest while in LOAD: remaining packet goes to DROP (drop pulses); partial packet is not resumed.

## Timing
- Reset: state IDLE, all FIFOs empty, counters 0; valid_out=0, data_out=0, busy=0, error=0, drop=0.
- Write latency: byte consumed at edge k visible at data_out/valid_out after edge k (1 cycle).
- error: registered, updated at the parity-consume edge; held until next header accept clears it.
- drop: registered, high the cycle after the consuming edge.
- Simultaneous read and write on full FIFO: full is pre-edge, write stalls one cycle (busy=1).
- Simultaneous flush and write/read on a port: flush wins; FIFO empty afterwards.
- Reset mid-packet: everything returns to reset values immediately; the source restarts the packet.

## Configuration
- ROUTER_PARITY_CHECK_EN defined: accumulator present, error behaves as above.
- Undefined: no accumulator; parity byte still consumed and written; error tied 0.

## Structure
- Package router_pkg: FSM state enum, ADDR_W function, header field slicing helper.
- Sub-module router_port_fifo (DATA_W, FIFO_DEPTH; we, re, flush, din, dout, empty, full; pointer-with-wrap-bit full/empty), instantiated NUM_PORTS times via generate.

## Test plan
- Header 0x04 (port 0), payload 0x11,0x22, parity 0x37 → port 0 holds 4 bytes, valid_out[0]=1 after header edge, error=0.
- Same packet with parity 0x00 → error=1 after parity edge; cleared on next header accept.
- Header 0x03 with NUM_PORTS=3 → drop pulse, no FIFO write, busy never asserted, next packet routed normally.
- Port 1 packet of FIFO_DEPTH+3 bytes, re[1]=0 for first 20 cycles → busy=1 when full, no byte lost once reads resume.
- Packet to port 2 left unread for TIMEOUT=30 cycles → valid_out[2]=0 on cycle 31, counter restarts.
- Second packet to non-empty port 0 → busy=1 until port 0 drained, then header accepted.

Source files
------------

// File: rtl/router_pkg.sv
// Shared router types and helpers: FSM state encoding, address width and header address extraction.
package router_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DROP
  } state_t;

  function automatic int addr_w(input int num_ports);
    return (num_ports <= 2) ? 1 : $clog2(num_ports);
  endfunction

  function automatic logic [31:0] hdr_addr(input logic [31:0] hdr, input int aw);
    return hdr & ((32'd1 << aw) - 32'd1);
  endfunction

endpackage

// File: rtl/router_1xn_if.sv
// Router byte-stream bundle: source side (pkt_valid/din/busy/error/drop) and reader side (re/data_out/valid_out).
interface router_1xn_if #(
  parameter int DATA_W    = 8,
  parameter int NUM_PORTS = 3
);
  logic                          pkt_valid;
  logic [DATA_W-1:0]             din;
  logic [NUM_PORTS-1:0]          re;
  logic [NUM_PORTS*DATA_W-1:0]   data_out;
  logic [NUM_PORTS-1:0]          valid_out;
  logic                          busy;
  logic                          error;
  logic                          drop;

  modport master (
    output pkt_valid, din, re,
    input  data_out, valid_out, busy, error, drop
  );

  modport slave (
    input  pkt_valid, din, re,
    output data_out, valid_out, busy, error, drop
  );
endinterface

// File: rtl/router_port_fifo.sv
// First-word-fall-through port FIFO, wrap-bit pointers; write ignored when full, read ignored when empty.
// Flush empties the FIFO at the edge and overrides a simultaneous push or pop.
module router_port_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic              flush,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              empty,
  output logic              full
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] PTR_ONE = (PW+1)'(1);

  logic [PW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic              push, pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign push  = we & ~full;
  assign pop   = re & ~empty;
  assign dout  = empty ? '0 : mem_q[rd_ptr_q[PW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[PW-1:0]] <= din;
  end

endmodule

// File: rtl/router_1xn.sv
// 1-to-NUM_PORTS packet router: header decode, per-port FWFT FIFOs, invalid-address drop, read-timeout flush.
// Bytes visible one cycle after consumption; busy holds the source. ROUTER_PARITY_CHECK_EN enables the parity error flag.
module router_1xn
  import router_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int NUM_PORTS  = 3,
  parameter int FIFO_DEPTH = 16,
  parameter int TIMEOUT    = 30
) (
  input logic         clk,
  input logic         rstn,
  router_1xn_if.slave bus
);
  localparam int ADDR_W = addr_w(NUM_PORTS);
  localparam int CW     = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] T_LAST  = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    dest_q, dest_d, addr;
  logic                 drop_q, drop_d;
  logic                 busy, addr_ok;
  logic [31:0]          hdr_field;
  logic [NUM_PORTS-1:0] fifo_we, fifo_empty, fifo_full, flush;
  logic [DATA_W-1:0]    fifo_dout [NUM_PORTS];
  logic [CW-1:0]        tcnt_q [NUM_PORTS];
  logic [CW-1:0]        tcnt_d [NUM_PORTS];
`ifdef ROUTER_PARITY_CHECK_EN
  logic [DATA_W-1:0]    par_q, par_d;
  logic                 error_q, error_d;
`endif

  assign hdr_field = hdr_addr(32'(bus.din), ADDR_W);
  assign addr_ok   = hdr_field < 32'(NUM_PORTS);
  assign addr      = hdr_field[ADDR_W-1:0];

  always_comb begin
    state_d = state_q;
    dest_d  = dest_q;
    drop_d  = 1'b0;
    busy    = 1'b0;
    fifo_we = '0;
`ifdef ROUTER_PARITY_CHECK_EN
    par_d   = par_q;
    error_d = error_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.pkt_valid) begin
          if (!addr_ok) begin
            drop_d  = 1'b1;
            state_d = DROP;
          end else if (!fifo_empty[addr]) begin
            busy = 1'b1;
          end else begin
            fifo_we[addr] = 1'b1;
            dest_d        = addr;
            state_d       = LOAD;
`ifdef ROUTER_PARITY_CHECK_EN
            par_d   = bus.din;
            error_d = 1'b0;
`endif
          end
        end
      end
      LOAD: begin
        if (fifo_full[dest_q]) begin
          busy = 1'b1;
        end else begin
          fifo_we[dest_q] = 1'b1;
          if (!bus.pkt_valid) state_d = IDLE;
`ifdef ROUTER_PARITY_CHECK_EN
          if (bus.pkt_valid) par_d = par_q ^ bus.din;
          else               error_d = (par_q != bus.din);
`endif
        end
        // A flushed destination loses its partial packet; swallow the rest of it.
        if (flush[dest_q] && state_d == LOAD) begin
          state_d = DROP;
          drop_d  = 1'b1;
        end
      end
      DROP: begin
        if (!bus.pkt_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    flush  = '0;
    tcnt_d = '{default: '0};
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!fifo_empty[i] && !bus.re[i]) begin
        if (tcnt_q[i] == T_LAST) flush[i] = 1'b1;
        else                     tcnt_d[i] = tcnt_q[i] + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state_q <= IDLE;
      dest_q  <= '0;
      drop_q  <= 1'b0;
      for (int i = 0; i < NUM_PORTS; i++) tcnt_q[i] <= '0;
`ifdef ROUTER_PARITY_CHECK_EN
      par_q   <= '0;
      error_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      dest_q  <= dest_d;
      drop_q  <= drop_d;
      for (int i = 0; i < NUM_PORTS; i++) tcnt_q[i] <= tcnt_d[i];
`ifdef ROUTER_PARITY_CHECK_EN
      par_q   <= par_d;
      error_q <= error_d;
`endif
    end
  end

  assign bus.busy = busy;
  assign bus.drop = drop_q;
`ifdef ROUTER_PARITY_CHECK_EN
  assign bus.error = error_q;
`else
  assign bus.error = 1'b0;
`endif

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    router_port_fifo #(
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rstn),
      .we    (fifo_we[i]),
      .re    (bus.re[i]),
      .flush (flush[i]),
      .din   (bus.din),
      .dout  (fifo_dout[i]),
      .empty (fifo_empty[i]),
      .full  (fifo_full[i])
    );
    assign bus.data_out[i*DATA_W +: DATA_W] = fifo_dout[i];
    assign bus.valid_out[i]                 = ~fifo_empty[i];
  end

endmodule

// File: tb/tb_router_1xn.sv
// Bench for router_1xn: packet vector table plus hand-written backpressure, timeout and reset sequences; port data scoreboarded.
module tb_router_1xn;
  localparam int NP = 3, DW = 8, DEPTH = 16, TO = 30;
`ifdef ROUTER_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic clk, rstn;
  router_1xn_if #(.DATA_W(DW), .NUM_PORTS(NP)) bus ();

  router_1xn #(.DATA_W(DW), .NUM_PORTS(NP), .FIFO_DEPTH(DEPTH), .TIMEOUT(TO)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  typedef struct {
    logic [7:0] hdr;
    int         len;
    bit         bad;
    bit         exp_drop;
    bit         exp_err;
  } vec_t;

  int           n_chk = 0, n_pass = 0;
  logic [7:0]   exp_q [NP][$];
  logic [NP-1:0] rd_mask = '0;
  bit           saw_busy;
  vec_t         vecs [8];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time %0t reached, limit 500000", $time);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, want);
  endtask

  // Reader: pops enabled ports and checks each head byte against the scoreboard.
  initial begin
    bus.re = '0;
    forever begin
      @(negedge clk);
      bus.re = rd_mask;
      for (int i = 0; i < NP; i++)
        if (!rstn && rd_mask[i] && bus.valid_out[i])
          chk($sformatf("port%0d_data", i), 32'(bus.data_out[i*DW +: DW]),
              (exp_q[i].size() > 0) ? 32'(exp_q[i].pop_front()) : 32'hDEAD_BEEF);
    end
  end

  task automatic send_byte(input logic v, input logic [7:0] b);
    int waited = 0;
    @(negedge clk);
    bus.pkt_valid = v;
    bus.din       = b;
    #1;
    while (bus.busy === 1'b1 && waited < 300) begin
      saw_busy = 1'b1;
      @(negedge clk);
      #1;
      waited++;
    end
    if (waited >= 300) chk("busy_release", 32'(bus.busy), 32'd0);
    @(posedge clk);
  endtask

  task automatic send_pkt(input logic [7:0] hdr, input int len, input bit bad, input bit push,
                          output logic drop_h, output logic err_h,
                          output logic drop_p, output logic err_p);
    logic [7:0] bytes[$];
    logic [7:0] par;
    bytes.push_back(hdr);
    par = hdr;
    for (int j = 0; j < len; j++) begin
      bytes.push_back(8'(8'h11 * (j + 1)));
      par ^= 8'(8'h11 * (j + 1));
    end
    bytes.push_back(bad ? ((par == 8'h00) ? 8'hFF : 8'h00) : par);
    if (push && hdr[1:0] < 2'(NP))
      foreach (bytes[k]) exp_q[hdr[1:0]].push_back(bytes[k]);
    saw_busy = 1'b0;
    drop_h = 1'b0;
    err_h  = 1'b0;
    for (int k = 0; k < bytes.size(); k++) begin
      send_byte(k != bytes.size() - 1, bytes[k]);
      #1;
      if (k == 0) begin
        drop_h = bus.drop;
        err_h  = bus.error;
      end
    end
    drop_p = bus.drop;
    err_p  = bus.error;
    bus.pkt_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size() != 0 || bus.valid_out != '0) && n < 300) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    chk("drain_valid", 32'(bus.valid_out), 32'd0);
    chk("drain_pending", 32'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size()), 32'd0);
  endtask

  initial begin
    logic dh, eh, dp, ep;
    vecs[0] = '{8'h04, 2, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{8'h04, 2, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{8'h03, 2, 1'b0, 1'b1, 1'b1};  // dropped: error keeps previous value
    vecs[3] = '{8'h05, 3, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{8'h06, 0, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{8'h07, 1, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{8'h01, 4, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{8'h00, 1, 1'b0, 1'b0, 1'b0};

    rstn = 1'b1;
    bus.pkt_valid = 1'b0;
    bus.din = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid_out", 32'(bus.valid_out), 32'd0);
    chk("rst_data_out", 32'(bus.data_out), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_error", 32'(bus.error), 32'd0);
    chk("rst_drop", 32'(bus.drop), 32'd0);
    @(negedge clk);
    rstn = 1'b0;

    rd_mask = '1;
    foreach (vecs[v]) begin
      send_pkt(vecs[v].hdr, vecs[v].len, vecs[v].bad, 1'b1, dh, eh, dp, ep);
      chk($sformatf("v%0d_drop_after_hdr", v), 32'(dh), 32'(vecs[v].exp_drop));
      chk($sformatf("v%0d_drop_after_par", v), 32'(dp), 32'd0);
      chk($sformatf("v%0d_err_after_par", v), 32'(ep), PAR_EN ? 32'(vecs[v].exp_err) : 32'd0);
      if (!vecs[v].exp_drop) chk($sformatf("v%0d_err_cleared_hdr", v), 32'(eh), 32'd0);
      else                   chk($sformatf("v%0d_no_busy_drop", v), 32'(saw_busy), 32'd0);
      wait_drain();
    end

    // Port 1 overfilled while unread for 20 cycles.
    rd_mask = '0;
    fork
      send_pkt(8'h01, DEPTH + 1, 1'b0, 1'b1, dh, eh, dp, ep);
      begin
        repeat (20) @(posedge clk);
        rd_mask[1] = 1'b1;
      end
    join
    chk("bp_busy_seen", 32'(saw_busy), 32'd1);
    chk("bp_err", 32'(ep), 32'd0);
    wait_drain();

    // Second packet to a still-occupied port 0 waits for the drain.
    rd_mask = '0;
    send_pkt(8'h04, 2, 1'b0, 1'b1, dh, eh, dp, ep);
    fork
      send_pkt(8'h08, 1, 1'b0, 1'b1, dh, eh, dp, ep);
      begin
        repeat (6) @(posedge clk);
        #1;
        chk("p0_hdr_blocked_busy", 32'(bus.busy), 32'd1);
        chk("p0_still_valid", 32'(bus.valid_out[0]), 32'd1);
        rd_mask[0] = 1'b1;
      end
    join
    chk("p0_busy_seen", 32'(saw_busy), 32'd1);
    wait_drain();

    // Unread port 2 flushed after TIMEOUT cycles, then a fresh packet survives as long again.
    rd_mask = '0;
    for (int r = 0; r < 2; r++) begin
      if (r == 1) begin
        exp_q[2].push_back(8'h02);
        exp_q[2].push_back(8'h02);
      end
      @(negedge clk);
      bus.pkt_valid = 1'b1;
      bus.din = 8'h02;
      @(posedge clk);
      @(negedge clk);
      bus.pkt_valid = 1'b0;
      @(posedge clk);
      repeat (28) @(posedge clk);
      #1;
      chk($sformatf("to%0d_cycle30_valid", r), 32'(bus.valid_out[2]), 32'd1);
      if (r == 0) begin
        @(posedge clk);
        #1;
        chk("to0_cycle31_flushed", 32'(bus.valid_out[2]), 32'd0);
      end else begin
        rd_mask[2] = 1'b1;
        wait_drain();
      end
    end

    // Reset in the middle of a packet, then the packet is resent.
    rd_mask = '0;
    @(negedge clk);
    bus.pkt_valid = 1'b1;
    bus.din = 8'h05;
    @(posedge clk);
    @(negedge clk);
    bus.din = 8'h11;
    @(posedge clk);
    #1;
    chk("pre_reset_valid", 32'(bus.valid_out[1]), 32'd1);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    chk("rst_mid_valid", 32'(bus.valid_out), 32'd0);
    chk("rst_mid_data", 32'(bus.data_out), 32'd0);
    bus.pkt_valid = 1'b0;
    @(negedge clk);
    rstn = 1'b0;
    rd_mask = '1;
    send_pkt(8'h05, 1, 1'b0, 1'b1, dh, eh, dp, ep);
    chk("resend_drop", 32'(dh), 32'd0);
    wait_drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
